// File: rtl/fir_coef_loader.sv
// Coefficient loader for an N-tap FIR filter: collects a shadow bank of coefficients and swaps it into the active bank on swap_en.
// Optional macro FIR_COEF_SYM_EN: load N/2 taps and mirror them into a linear-phase bank.
module fir_coef_loader #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_data,
  input  logic              wr_last,
  input  logic              swap_en,
  output logic [16*N-1:0]   filter_params,
  output logic              params_valid,
  output logic              swap_done,
  output logic              err_len
);

`ifdef FIR_COEF_SYM_EN
  localparam int L = N / 2;
`else
  localparam int L = N;
`endif
  localparam int              IDX_W    = $clog2(L);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PEND
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_count, w_count_next;
  logic               r_swap_done, r_err_len, r_params_valid;
  logic [16*N-1:0]    r_filter_params, w_commit_bank;
  logic [15:0]        r_shadow [L];
  logic               w_accept, w_err_next, w_swap_next, w_commit;
  logic [IDX_W-1:0]   w_idx;

  assign wr_ready      = (r_state != S_PEND);
  assign w_accept      = wr_valid & wr_ready;
  assign w_idx         = r_count[IDX_W-1:0];
  assign filter_params = r_filter_params;
  assign params_valid  = r_params_valid;
  assign swap_done     = r_swap_done;
  assign err_len       = r_err_len;

  // IDLE always holds count=0, so it shares the LOAD acceptance rules.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_next = r_state;
    w_count_next = r_count;
    w_err_next   = 1'b0;
    w_swap_next  = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (r_count == LAST_CNT && wr_last) begin
            w_state_next = S_PEND;
            w_count_next = '0;
          end else if (r_count == LAST_CNT || wr_last) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
            w_err_next   = 1'b1;
          end else begin
            w_state_next = S_LOAD;
            w_count_next = r_count + CNT_W'(1);
          end
        end
      end
      S_PEND: begin
        if (swap_en) begin
          w_state_next = S_IDLE;
          w_swap_next  = 1'b1;
          w_commit     = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_comb begin
    w_commit_bank = '0;
    for (int k = 0; k < L; k++) begin
      w_commit_bank[16*k +: 16] = r_shadow[k];
`ifdef FIR_COEF_SYM_EN
      w_commit_bank[16*(N-1-k) +: 16] = r_shadow[k];
`endif
    end
  end

  // NOTE: the shadow bank has no reset; its contents only matter after a complete load rewrites every entry.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow[w_idx] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_swap_done     <= 1'b0;
      r_err_len       <= 1'b0;
      r_params_valid  <= 1'b0;
      r_filter_params <= '0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_swap_done <= w_swap_next;
      r_err_len   <= w_err_next;
      if (w_commit) begin
        r_filter_params <= w_commit_bank;
        r_params_valid  <= 1'b1;
      end
    end
  end

endmodule
